// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg.sv
// ============================================================================
// Module : gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg
// Brief  : Shared types and default constants for the delay-chain monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg;

  localparam int DLYMON_CNT_W       = 8;
  localparam int DLYMON_SYNC_STAGES = 2;
  localparam int DLYMON_TIMEOUT     = 255;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dlymon_state_e;

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon_if.sv
// ============================================================================
// Module : gf180mcu_fd_sc_mcu7t5v0__dlymon_if
// Brief  : Request/launch/return/result bundle of the delay-chain monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface gf180mcu_fd_sc_mcu7t5v0__dlymon_if #(
  parameter int CNT_W = gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg::DLYMON_CNT_W
);
  logic             START;
  logic             Z;
  logic             I;
  logic             BUSY;
  logic             DONE;
  logic             TOUT;
  logic [CNT_W-1:0] COUNT;

  modport master (
    output START,
    output I,
    input  Z,
    input  BUSY,
    input  DONE,
    input  TOUT,
    input  COUNT
  );

  modport slave (
    input  START,
    input  I,
    output Z,
    output BUSY,
    output DONE,
    output TOUT,
    output COUNT
  );
endinterface

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon_sync.sv
// ============================================================================
// Module : gf180mcu_fd_sc_mcu7t5v0__dlymon_sync
// Brief  : SYNC_STAGES-flop synchronizer for the chain return level.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__dlymon_sync #(
  parameter int SYNC_STAGES = gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg::DLYMON_SYNC_STAGES
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic i_async,
  output logic      o_sync
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlymon.sv
// ============================================================================
// Module : gf180mcu_fd_sc_mcu7t5v0__dlymon
// Brief  : Launches an edge into a delay chain and times its synchronized return.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__dlymon
  import gf180mcu_fd_sc_mcu7t5v0__dlymon_pkg::*;
#(
  parameter int CNT_W       = DLYMON_CNT_W,
  parameter int SYNC_STAGES = DLYMON_SYNC_STAGES,
  parameter int TIMEOUT     = DLYMON_TIMEOUT
) (
  input wire logic CLK,
  input wire logic RST,
  gf180mcu_fd_sc_mcu7t5v0__dlymon_if.slave bus
);

  localparam logic [0:0]       S_IDLE    = ST_IDLE;
  localparam logic [0:0]       S_WAIT    = ST_WAIT;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  logic [0:0]       state_q, state_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_i;

  gf180mcu_fd_sc_mcu7t5v0__dlymon_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_async (bus.I),
    .o_sync  (sync_i)
  );

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tout_d  = tout_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          z_d     = ~z_q;
          cnt_d   = '0;
          tout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A return seen on the timeout edge still counts as a return.
        if (sync_i == z_q) begin
          count_d = cnt_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == C_TIMEOUT) begin
          count_d = C_TIMEOUT;
          tout_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Z     = z_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.TOUT  = tout_q;
  assign bus.COUNT = count_q;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlymon.sv
// ============================================================================
// Module : tb_gf180mcu_fd_sc_mcu7t5v0__dlymon
// Brief  : Self-checking bench with a behavioural delay-chain model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__dlymon;

  localparam int SYNC = 2;
  localparam int TO_A = 255;
  localparam int TO_B = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__dlymon_if #(.CNT_W(8)) bus_a ();
  gf180mcu_fd_sc_mcu7t5v0__dlymon_if #(.CNT_W(8)) bus_b ();

  gf180mcu_fd_sc_mcu7t5v0__dlymon #(
    .CNT_W(8), .SYNC_STAGES(SYNC), .TIMEOUT(TO_A)
  ) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  gf180mcu_fd_sc_mcu7t5v0__dlymon #(
    .CNT_W(8), .SYNC_STAGES(SYNC), .TIMEOUT(TO_B)
  ) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Chain model: I follows Z delayed by dly whole clock cycles, or is held.
  logic [31:0] hist_a = '0;
  logic [31:0] hist_b = '0;
  int          dly_a  = 0;
  int          dly_b  = 0;
  logic        hold_a = 1'b0;
  logic        hold_val_a = 1'b0;

  always @(posedge CLK) begin
    hist_a <= {hist_a[30:0], bus_a.Z};
    hist_b <= {hist_b[30:0], bus_b.Z};
  end

  assign bus_a.I = hold_a ? hold_val_a : ((dly_a == 0) ? bus_a.Z : hist_a[dly_a-1]);
  assign bus_b.I = (dly_b == 0) ? bus_b.Z : hist_b[dly_b-1];

  initial begin
    bus_a.START = 1'b0;
    bus_b.START = 1'b0;
  end

  function automatic int exp_count(input int d, input int to);
    return (d + SYNC > to) ? to : d + SYNC;
  endfunction

  task automatic wait_done_a(input logic z_exp, output bit seen, output int busy_n,
                             output bit z_moved);
    seen = 1'b0; busy_n = 0; z_moved = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus_a.DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus_a.BUSY === 1'b1) busy_n++;
      if (bus_a.Z !== z_exp) z_moved = 1'b1;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({bus_a.Z, bus_a.BUSY, bus_a.DONE, bus_a.TOUT, bus_a.COUNT} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_a: got Z/BUSY/DONE/TOUT/COUNT=%b%b%b%b/%0d want all 0",
               bus_a.Z, bus_a.BUSY, bus_a.DONE, bus_a.TOUT, bus_a.COUNT);
    end
    n_checks++;
    if ({bus_b.Z, bus_b.BUSY, bus_b.DONE, bus_b.TOUT, bus_b.COUNT} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_b: got Z/BUSY/DONE/TOUT/COUNT=%b%b%b%b/%0d want all 0",
               bus_b.Z, bus_b.BUSY, bus_b.DONE, bus_b.TOUT, bus_b.COUNT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic measure_a(input int d, input bit spam, input bit hold, input string tag);
    int   exp_c;
    bit   exp_t;
    logic z0;
    bit   seen;
    bit   z_moved;
    int   busy_n;
    logic [7:0] cnt_held;
    exp_c = hold ? TO_A : exp_count(d, TO_A);
    exp_t = hold ? 1'b1 : (d + SYNC > TO_A);
    dly_a  = d;
    hold_a = 1'b0;
    repeat (34) @(negedge CLK);
    z0 = bus_a.Z;
    if (hold) begin
      hold_val_a = z0;
      hold_a     = 1'b1;
    end
    bus_a.START = 1'b1;
    @(negedge CLK);
    if (!spam) bus_a.START = 1'b0;
    n_checks++;
    if ({bus_a.Z, bus_a.BUSY, bus_a.TOUT, bus_a.DONE} !== {~z0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s accept: got Z/BUSY/TOUT/DONE=%b%b%b%b want %b100",
               tag, bus_a.Z, bus_a.BUSY, bus_a.TOUT, bus_a.DONE, ~z0);
    end
    wait_done_a(~z0, seen, busy_n, z_moved);
    bus_a.START = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no DONE within 400 cycles want DONE", tag);
    end else begin
      n_checks++;
      if ({bus_a.COUNT, bus_a.TOUT, bus_a.BUSY} !== {8'(exp_c), exp_t, 1'b0}) begin
        n_fail++;
        $display("FAIL %s result: got COUNT=%0d TOUT=%b BUSY=%b want COUNT=%0d TOUT=%b BUSY=0",
                 tag, bus_a.COUNT, bus_a.TOUT, bus_a.BUSY, exp_c, exp_t);
      end
      n_checks++;
      if (busy_n != exp_c + 1 || z_moved || bus_a.Z !== ~z0) begin
        n_fail++;
        $display("FAIL %s busy_z: got busy_cycles=%0d z_moved=%b Z=%b want %0d 0 %b",
                 tag, busy_n, z_moved, bus_a.Z, exp_c + 1, ~z0);
      end
    end
    cnt_held = bus_a.COUNT;
    @(negedge CLK);
    n_checks++;
    if ({bus_a.DONE, bus_a.BUSY, bus_a.Z, bus_a.COUNT} !== {1'b0, 1'b0, ~z0, cnt_held}) begin
      n_fail++;
      $display("FAIL %s after_done: got DONE=%b BUSY=%b Z=%b COUNT=%0d want 0 0 %b %0d",
               tag, bus_a.DONE, bus_a.BUSY, bus_a.Z, bus_a.COUNT, ~z0, cnt_held);
    end
    hold_a = 1'b0;
  endtask

  task automatic test_zero_loop();
    n_checks++;
    if (bus_a.Z !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_loop_z0: got Z=%b want 0", bus_a.Z);
    end
    measure_a(0, 1'b0, 1'b0, "zero_loop");
  endtask

  task automatic test_delay5();
    measure_a(5, 1'b0, 1'b0, "delay5_first");
    measure_a(5, 1'b0, 1'b0, "delay5_repeat");
  endtask

  task automatic test_timeout();
    measure_a(0, 1'b0, 1'b1, "timeout");
    measure_a(0, 1'b0, 1'b0, "after_timeout");
  endtask

  task automatic test_start_spam();
    measure_a(6, 1'b1, 1'b0, "start_spam");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      measure_a(int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    int   d;
    logic z0;
    bit   seen;
    bit   z_moved;
    int   busy_n;
    d = int'($urandom_range(1, 10));
    dly_a = d;
    repeat (34) @(negedge CLK);
    z0 = bus_a.Z;
    bus_a.START = 1'b1;
    @(negedge CLK);
    wait_done_a(~z0, seen, busy_n, z_moved);
    @(negedge CLK);
    bus_a.START = 1'b0;
    n_checks++;
    if ({seen, bus_a.BUSY, bus_a.DONE, bus_a.Z} !== {1'b1, 1'b1, 1'b0, z0}) begin
      n_fail++;
      $display("FAIL b2b_relaunch: got seen=%b BUSY=%b DONE=%b Z=%b want 1 1 0 %b",
               seen, bus_a.BUSY, bus_a.DONE, bus_a.Z, z0);
    end
    wait_done_a(z0, seen, busy_n, z_moved);
    n_checks++;
    if (!seen || bus_a.COUNT !== 8'(d + SYNC) || bus_a.TOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_result: got seen=%b COUNT=%0d TOUT=%b want 1 %0d 0",
               seen, bus_a.COUNT, bus_a.TOUT, d + SYNC);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_wait();
    bit stray_done;
    dly_a = 5;
    repeat (34) @(negedge CLK);
    bus_a.START = 1'b1;
    @(negedge CLK);
    bus_a.START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    n_checks++;
    if ({bus_a.Z, bus_a.BUSY, bus_a.COUNT, bus_a.DONE, bus_a.TOUT} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_wait_reset: got Z/BUSY/COUNT/DONE/TOUT=%b%b/%0d/%b%b want all 0",
               bus_a.Z, bus_a.BUSY, bus_a.COUNT, bus_a.DONE, bus_a.TOUT);
    end
    stray_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus_a.DONE !== 1'b0) stray_done = 1'b1;
      @(negedge CLK);
    end
    n_checks++;
    if (stray_done) begin
      n_fail++;
      $display("FAIL mid_wait_no_done: got DONE pulse want none");
    end
    measure_a(5, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_coincide(input int d, input string tag);
    int exp_c;
    bit exp_t;
    bit seen;
    exp_c = exp_count(d, TO_B);
    exp_t = (d + SYNC > TO_B);
    dly_b = d;
    repeat (34) @(negedge CLK);
    bus_b.START = 1'b1;
    @(negedge CLK);
    bus_b.START = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_b.DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (!seen || bus_b.COUNT !== 8'(exp_c) || bus_b.TOUT !== exp_t) begin
      n_fail++;
      $display("FAIL %s: got seen=%b COUNT=%0d TOUT=%b want 1 %0d %b",
               tag, seen, bus_b.COUNT, bus_b.TOUT, exp_c, exp_t);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_zero_loop();
    test_delay5();
    test_timeout();
    test_start_spam();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    test_coincide(2, "coincide");
    test_coincide(3, "short_timeout");
    test_coincide(1, "short_return");
    test_coincide(int'($urandom_range(0, 6)), "short_random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
